// File: rtl/gain_ctrl_pkg.sv
// Shared types and helpers for the ECG gain-ranging controller.
package gain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_STEP    = 3'd3,
    ST_SETTLE  = 3'd4
  } state_t;

  localparam int ADC_W_DEF = 12;

  // Mid-scale code of an offset-binary converter of width w.
  function automatic int mid_code(input int w);
    return 1 << (w - 1);
  endfunction

  localparam int MID = mid_code(ADC_W_DEF);

  // A code is clipped when it sits on either rail.
  function automatic logic is_clip_code(input logic [31:0] code, input int w);
    return (code == 32'd0) || (code == ((32'd1 << w) - 32'd1));
  endfunction

endpackage

// File: rtl/window_peak_detector.sv
// Per-window peak deviation from mid-scale, saturating clip count and sample count.
module window_peak_detector
  import gain_ctrl_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int WIN_LEN  = 256,
  parameter int CLIP_THR = 4,
  parameter int CLIP_W   = $clog2(CLIP_THR + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [ADC_W-1:0]  i_sample,
  output logic [ADC_W-1:0]  o_peak,
  output logic [CLIP_W-1:0] o_clip_cnt,
  output logic              o_window_full
);

  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [ADC_W-1:0]  MID_CODE = ADC_W'(mid_code(ADC_W));
  localparam logic [CLIP_W-1:0] CLIP_MAX = CLIP_W'(CLIP_THR);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIN_LEN - 1);

  logic [ADC_W-1:0]  r_peak;
  logic [CLIP_W-1:0] r_clip_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADC_W-1:0]  w_dev;
  logic              w_clip;

  assign w_dev  = (i_sample >= MID_CODE) ? (i_sample - MID_CODE) : (MID_CODE - i_sample);
  assign w_clip = is_clip_code(32'(i_sample), ADC_W);

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_peak     <= '0;
      r_clip_cnt <= '0;
      r_cnt      <= '0;
    end else if (i_valid) begin
      if (w_dev > r_peak) r_peak <= w_dev;
      if (w_clip && (r_clip_cnt != CLIP_MAX)) r_clip_cnt <= r_clip_cnt + 1'b1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High on the cycle the last sample of the window is being accepted.
  assign o_window_full = i_valid && !i_clear && (r_cnt == CNT_LAST);
  assign o_peak        = r_peak;
  assign o_clip_cnt    = r_clip_cnt;

endmodule

// File: rtl/gain_ranging_ctrl.sv
// Auto-ranging FSM: measures windows, steps the relay gain index, blanks while relays settle.
module gain_ranging_ctrl
  import gain_ctrl_pkg::*;
#(
  parameter int ADC_W      = ADC_W_DEF,
  parameter int WIN_LEN    = 256,
  parameter int HI_THR     = 1900,
  parameter int LO_THR     = 500,
  parameter int CLIP_THR   = 4,
  parameter int SETTLE_CYC = 50000,
  parameter int IDX_MIN    = 1,
  parameter int IDX_MAX    = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             auto_en,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  input  logic [3:0]       gain_idx,
  output logic             step_en,
  output logic             to_high,
  output logic             to_low,
  output logic             settling,
  output logic [ADC_W-1:0] last_peak,
  output logic             window_done,
  output state_t           dbg_state
);

  localparam int CLIP_W = $clog2(CLIP_THR + 1);
  localparam int SET_W  = $clog2(SETTLE_CYC);
  localparam logic [ADC_W-1:0]  HI_T     = ADC_W'(HI_THR);
  localparam logic [ADC_W-1:0]  LO_T     = ADC_W'(LO_THR);
  localparam logic [CLIP_W-1:0] CLIP_T   = CLIP_W'(CLIP_THR);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [3:0]        IDX_LO   = 4'(IDX_MIN);
  localparam logic [3:0]        IDX_HI   = 4'(IDX_MAX);

  state_t            r_state;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              r_step_en, r_to_high, r_to_low, r_settling, r_window_done;
  logic [ADC_W-1:0]  r_last_peak;
  logic [ADC_W-1:0]  w_peak;
  logic [CLIP_W-1:0] w_clip_cnt;
  logic              w_window_full, w_clear, w_valid;

  // Accumulators only run while measuring; leaving MEASURE for any reason empties them.
  assign w_clear = (r_state != ST_MEASURE) || !auto_en;
  assign w_valid = sample_valid && (r_state == ST_MEASURE);

  window_peak_detector #(
    .ADC_W   (ADC_W),
    .WIN_LEN (WIN_LEN),
    .CLIP_THR(CLIP_THR),
    .CLIP_W  (CLIP_W)
  ) u_wpd (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_valid      (w_valid),
    .i_sample     (sample),
    .o_peak       (w_peak),
    .o_clip_cnt   (w_clip_cnt),
    .o_window_full(w_window_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_settle_cnt  <= '0;
      r_step_en     <= 1'b0;
      r_to_high     <= 1'b0;
      r_to_low      <= 1'b0;
      r_settling    <= 1'b0;
      r_window_done <= 1'b0;
      r_last_peak   <= '0;
    end else begin
      r_step_en     <= 1'b0;
      r_to_high     <= 1'b0;
      r_to_low      <= 1'b0;
      r_window_done <= 1'b0;
      if (!auto_en) begin
        r_state      <= ST_IDLE;
        r_settling   <= 1'b0;
        r_settle_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE:    r_state <= ST_MEASURE;
          ST_MEASURE: if (w_window_full) r_state <= ST_DECIDE;
          ST_DECIDE: begin
            r_last_peak   <= w_peak;
            r_window_done <= 1'b1;
            // Step pulse is launched here so it is visible during the STEP cycle.
            if ((w_clip_cnt >= CLIP_T) || (w_peak >= HI_T)) begin
              if (gain_idx > IDX_LO) begin
                r_state   <= ST_STEP;
                r_step_en <= 1'b1;
                r_to_high <= 1'b1;
              end else begin
                r_state <= ST_MEASURE;
              end
            end else if (w_peak < LO_T) begin
              if (gain_idx < IDX_HI) begin
                r_state   <= ST_STEP;
                r_step_en <= 1'b1;
                r_to_low  <= 1'b1;
              end else begin
                r_state <= ST_MEASURE;
              end
            end else begin
              r_state <= ST_MEASURE;
            end
          end
          ST_STEP: begin
            r_state      <= ST_SETTLE;
            r_settling   <= 1'b1;
            r_settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (r_settle_cnt == SET_LAST) begin
              r_state      <= ST_MEASURE;
              r_settling   <= 1'b0;
              r_settle_cnt <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign step_en     = r_step_en;
  assign to_high     = r_to_high;
  assign to_low      = r_to_low;
  assign settling    = r_settling;
  assign last_peak   = r_last_peak;
  assign window_done = r_window_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_gain_ranging_ctrl.sv
// Directed bench for gain_ranging_ctrl with an 8-sample window and 10-cycle settle.
module tb_gain_ranging_ctrl;
  import gain_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        auto_en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic [3:0]  gain_idx = 4'd5;
  logic        step_en, to_high, to_low, settling, window_done;
  logic [11:0] last_peak;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  gain_ranging_ctrl #(
    .ADC_W(12), .WIN_LEN(8), .HI_THR(1900), .LO_THR(500), .CLIP_THR(4),
    .SETTLE_CYC(10), .IDX_MIN(1), .IDX_MAX(12)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .auto_en     (auto_en),
    .sample_valid(sample_valid),
    .sample      (sample),
    .gain_idx    (gain_idx),
    .step_en     (step_en),
    .to_high     (to_high),
    .to_low      (to_low),
    .settling    (settling),
    .last_peak   (last_peak),
    .window_done (window_done),
    .dbg_state   (dbg_state)
  );

  // Inputs change and outputs are observed 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Eight valid samples (first n_alt use v_alt) with one idle gap carrying junk.
  task automatic send_window(input logic [11:0] v_alt, input int n_alt, input logic [11:0] v);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        sample_valid = 1'b0;
        sample = 12'd0;
        tick();
      end
      sample_valid = 1'b1;
      sample = (i < n_alt) ? v_alt : v;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic window_check(input string tag, input logic [11:0] v_alt, input int n_alt,
                              input logic [11:0] v, input logic [3:0] idx,
                              input logic [11:0] exp_peak, input logic exp_hi, input logic exp_lo);
    int  cnt;
    logic stray;
    gain_idx = idx;
    send_window(v_alt, n_alt, v);
    chk({tag, "_decide"}, 32'(dbg_state), 32'(ST_DECIDE));
    tick();
    chk({tag, "_wdone"}, 32'(window_done), 32'd1);
    chk({tag, "_peak"}, 32'(last_peak), 32'(exp_peak));
    chk({tag, "_step"}, 32'(step_en), 32'(exp_hi | exp_lo));
    chk({tag, "_hi"}, 32'(to_high), 32'(exp_hi));
    chk({tag, "_lo"}, 32'(to_low), 32'(exp_lo));
    if (exp_hi | exp_lo) begin
      tick();
      chk({tag, "_step_off"}, 32'({step_en, to_high, to_low}), 32'd0);
      chk({tag, "_settle_on"}, 32'(settling), 32'd1);
      // Rail-level samples during blanking must never reach the next window.
      sample_valid = 1'b1;
      sample = 12'd0;
      cnt = 1;
      stray = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick();
        stray |= step_en | window_done;
        if (!settling) break;
        cnt++;
      end
      sample_valid = 1'b0;
      chk({tag, "_settle_len"}, 32'(cnt), 32'd10);
      chk({tag, "_settle_quiet"}, 32'(stray), 32'd0);
      chk({tag, "_remeasure"}, 32'(dbg_state), 32'(ST_MEASURE));
    end else begin
      tick();
      chk({tag, "_wdone_off"}, 32'(window_done), 32'd0);
      chk({tag, "_measure"}, 32'(dbg_state), 32'(ST_MEASURE));
    end
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_outs", 32'({step_en, to_high, to_low, settling, window_done}), 32'd0);
    chk("rst_peak", 32'(last_peak), 32'd0);
    reset = 1'b0;
    auto_en = 1'b1;
    tick();
    chk("en_measure", 32'(dbg_state), 32'(ST_MEASURE));

    window_check("t1_dev1000", 12'd3048, 0, 12'd3048, 4'd5, 12'd1000, 1'b0, 1'b0);
    window_check("t2_spike", 12'd4000, 1, 12'd3048, 4'd5, 12'd1952, 1'b1, 1'b0);
    window_check("t5_after_settle", 12'd3048, 0, 12'd3048, 4'd5, 12'd1000, 1'b0, 1'b0);
    window_check("t3_low", 12'd2100, 0, 12'd2100, 4'd5, 12'd52, 1'b0, 1'b1);
    window_check("t3_low_max", 12'd2100, 0, 12'd2100, 4'd12, 12'd52, 1'b0, 1'b0);
    window_check("t4_clip", 12'd4095, 4, 12'd2048, 4'd5, 12'd2047, 1'b1, 1'b0);
    window_check("t4_clip_min", 12'd0, 4, 12'd2048, 4'd1, 12'd2048, 1'b0, 1'b0);
    window_check("b_hi_eq", 12'd3948, 0, 12'd3948, 4'd2, 12'd1900, 1'b1, 1'b0);
    window_check("b_hi_below", 12'd3947, 0, 12'd3947, 4'd2, 12'd1899, 1'b0, 1'b0);
    window_check("b_lo_below", 12'd1549, 0, 12'd1549, 4'd11, 12'd499, 1'b0, 1'b1);
    window_check("b_lo_eq", 12'd1548, 0, 12'd1548, 4'd11, 12'd500, 1'b0, 1'b0);

    // auto_en dropped mid-SETTLE
    gain_idx = 4'd5;
    send_window(12'd4000, 1, 12'd3048);
    tick();
    chk("t6a_step", 32'(step_en), 32'd1);
    tick();
    tick();
    tick();
    chk("t6a_settling", 32'(settling), 32'd1);
    auto_en = 1'b0;
    tick();
    chk("t6a_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6a_outs", 32'({step_en, to_high, to_low, settling, window_done}), 32'd0);
    tick();
    chk("t6a_hold", 32'({step_en, settling, window_done}), 32'd0);
    auto_en = 1'b1;
    tick();
    chk("t6a_reen", 32'(dbg_state), 32'(ST_MEASURE));
    window_check("t6a_fresh", 12'd3048, 0, 12'd3048, 4'd5, 12'd1000, 1'b0, 1'b0);

    // auto_en dropped mid-MEASURE with a partial high-deviation window
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample = 12'd4000;
      tick();
    end
    sample_valid = 1'b0;
    auto_en = 1'b0;
    tick();
    chk("t6b_idle", 32'(dbg_state), 32'(ST_IDLE));
    auto_en = 1'b1;
    tick();
    window_check("t6b_fresh", 12'd3048, 0, 12'd3048, 4'd5, 12'd1000, 1'b0, 1'b0);

    // Reset while the step pulse is out
    send_window(12'd4000, 1, 12'd3048);
    tick();
    chk("t6c_step", 32'({step_en, to_high}), 32'd3);
    reset = 1'b1;
    tick();
    chk("t6c_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6c_rst_outs", 32'({step_en, to_high, to_low, settling, window_done}), 32'd0);
    chk("t6c_rst_peak", 32'(last_peak), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6c_no_pulse", 32'({step_en, to_high, to_low, settling}), 32'd0);
    chk("t6c_measure", 32'(dbg_state), 32'(ST_MEASURE));
    window_check("t6c_fresh", 12'd3048, 0, 12'd3048, 4'd5, 12'd1000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gain_ranging_ctrl.md
Name: gain_ranging_ctrl

Overview:
Automatic gain-ranging controller for the ECG front-end relay gain ladder. It monitors the ADC sample stream over fixed windows and measures peak deviation from mid-scale and the number of clipped samples. It then issues single-cycle step commands (to_high/to_low plus step_en) to the 4-bit gain-index counter and blanks measurement while the relays settle. It sits between the ADC sample interface and the relay gain-index counter.

Parameters:
ADC_W, 12, ADC sample width, offset-binary
WIN_LEN, 256, valid samples per measurement window
HI_THR, 1900, peak deviation at or above this value requests a larger input range (to_high)
LO_THR, 500, peak deviation below this value requests more gain (to_low); must be < HI_THR
CLIP_THR, 4, clipped samples per window that force to_high
SETTLE_CYC, 50000, clock cycles of blanking after a step
IDX_MIN, 1, lowest gain index to_high may leave (no step issued when gain_idx <= IDX_MIN)
IDX_MAX, 12, highest gain index to_low may leave (no step issued when gain_idx >= IDX_MAX)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
auto_en  in  1  enables auto-ranging; low forces IDLE
sample_valid  in  1  qualifies sample, one cycle per sample
sample  in  ADC_W  ADC code, offset binary
gain_idx  in  4  current index from the gain-index counter
step_en  out  1  one-cycle enable to the counter
to_high  out  1  one-cycle: decrement index (larger range)
to_low  out  1  one-cycle: increment index (more gain)
settling  out  1  high during SETTLE
last_peak  out  ADC_W  peak deviation of last completed window
window_done  out  1  one-cycle pulse when a window closes

Behaviour:
- All outputs registered. Reset: state=IDLE, step_en=to_high=to_low=settling=window_done=0, last_peak=0, internal peak/clip/sample/settle counters=0.
- Deviation: MID=2^(ADC_W-1); dev = sample>=MID ? sample-MID : MID-sample (ADC_W bits, max MID). Clip = sample==0 or sample==all-ones.
- States: IDLE, MEASURE, DECIDE, STEP, SETTLE.
- IDLE: when auto_en=1, go to MEASURE next cycle with accumulators cleared.
- MEASURE: on each sample_valid, peak=max(peak,dev), clip_cnt increments and saturates at CLIP_THR, and sample_cnt increments. On the cycle the WIN_LEN-th valid sample is accepted (that sample is included), go to DECIDE. Samples without sample_valid are ignored.
- DECIDE (1 cycle): last_peak<=peak and window_done=1 (registered, so both are visible in the following cycle). Priority:
  1. clip_cnt>=CLIP_THR or peak>=HI_THR: if gain_idx>IDX_MIN go to STEP(high), else go to MEASURE.
  2. Else if peak<LO_THR: if gain_idx<IDX_MAX go to STEP(low), else go to MEASURE.
  3. Else go to MEASURE.
  Accumulators clear on exit from DECIDE.
- STEP (1 cycle): step_en=1 with exactly one of to_high/to_low =1. Then go to SETTLE. No step is ever emitted with both directions set.
- SETTLE: settling=1 for exactly SETTLE_CYC cycles. Samples are discarded. Then go to MEASURE with a fresh window.
- auto_en low in any state: next state IDLE, all pulses 0, accumulators cleared. A STEP pulse already registered still completes (single cycle). SETTLE is abandoned.
- Reset mid-operation: immediate return to the reset values above. No partial pulse follows.
- Latency: the last window sample to step_en high is 2 cycles. Step_en to the first counted sample is SETTLE_CYC+1 cycles.
- gain_idx is sampled only in DECIDE.

Decomposition:
- Package gain_ctrl_pkg: state enum, MID constant, and a clipped-code helper/constant.
- One sub-module, window_peak_detector, holds the dev computation, peak max, the saturating clip counter, the sample counter and the window_full flag, with a clear input. The FSM, settle counter and output registers stay in gain_ranging_ctrl.

Test Plan:
(Bench parameters: WIN_LEN=8, SETTLE_CYC=10, HI_THR=1900, LO_THR=500, CLIP_THR=4.)
1. Reset, auto_en=1, gain_idx=5, 8 samples at 2048+1000 -> window_done, last_peak=1000, no step, new window starts.
2. 8 samples with one at 4000 (dev 1952), gain_idx=5 -> step_en and to_high pulse 1 cycle, to_low=0, 2 cycles after the last sample; settling high exactly 10 cycles.
3. 8 samples at 2100 (dev 52), gain_idx=5 -> single to_low pulse. Repeat with gain_idx=12 -> no pulse, stays in MEASURE.
4. 4 samples at 4095 plus 4 at 2048 -> to_high. With gain_idx=1 -> no pulse.
5. Samples during SETTLE at 0 -> ignored; the following window of dev 1000 gives no step, and last_peak=1000.
6. Drop auto_en mid-SETTLE and mid-MEASURE, and assert reset at STEP -> IDLE, all outputs 0, no extra pulse; re-enable starts a fresh window.
